sid_write_arb: RTL and testbench
================================

SID_WRITE_ARB -- requirements
Module: sid_write_arb

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, B-side write FIFO depth; SHALL be a power of two and at least 2.
REQ-002 Parameter FAIR_MAX, default 2, max consecutive A grants while B is pending; SHALL be 1..7.
REQ-003 clk  in  1  master clock; single clock domain.
REQ-004 iRstN  in  1  reset, asynchronous assert, active-low.
REQ-005 clkEn  in  1  1 MHz SID enable; write-issue slot qualifier.
REQ-006 iAValid / oAReady  in / out  1 / 1  requester A (C64 bus) write handshake.
REQ-007 iAAddr / iAData  in  5 / 8  requester A register address / data.
REQ-008 iBValid / oBReady  in / out  1 / 1  requester B (stream player) write handshake.
REQ-009 iBAddr / iBData  in  5 / 8  requester B register address / data.
REQ-010 oWE  out  1  one-cycle write strobe to the SID register port.
REQ-011 oAddr / oData  out  5 / 8  SID register address / write data.
REQ-012 oGrantB  out  1  high with oWE when the issued write came from B.
REQ-013 oBLevel  out  log2(FIFO_DEPTH)+1  current B FIFO occupancy.

Function
REQ-014 A path: single holding register; oAReady = not aFull; accept on iAValid and oAReady; aFull set on accept, cleared on A grant.
REQ-015 A accept and A grant SHALL never occur in the same cycle; an accepted entry is grant-eligible from the next cycle.
REQ-016 B path: FIFO_DEPTH-entry FIFO, first-in first-out; oBReady = (level < FIFO_DEPTH); push on iBValid and oBReady; pop on B grant.
REQ-017 Simultaneous B push and pop SHALL leave level unchanged and preserve order; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 A pushed entry SHALL be grant-eligible from the cycle after the push (no same-cycle push-to-grant bypass).
REQ-019 Arbitration SHALL occur only in cycles with clkEn=1, granting at most one write per clkEn cycle; no grant when clkEn=0.
REQ-020 Priority: A wins when both are pending, unless starve counter equals FAIR_MAX, in which case B wins.
REQ-021 Starve counter (3 bits) SHALL increment on each A grant while the B FIFO is non-empty, and SHALL clear on a B grant or whenever the B FIFO is empty.
REQ-022 oWE, oAddr, oData and oGrantB SHALL be registered and asserted the cycle after the grant cycle; oWE SHALL be high for exactly one cycle per grant.
REQ-023 oAddr/oData SHALL hold the last issued values while oWE=0.
REQ-024 oGrantB SHALL be 0 whenever oWE=0.
REQ-025 Minimum latency SHALL be 2 cycles from accept: accept at t, grant at the first clkEn cycle at or after t+1, oWE one cycle later.
REQ-026 Writes SHALL be issued unmodified; no address filtering, and all addresses 0x00-0x1F are passed.
REQ-027 oBLevel SHALL reflect occupancy registered at the end of the previous cycle.

Reset
REQ-028 iRstN low SHALL immediately clear aFull, the FIFO pointers and level, the starve counter, oWE, oGrantB, oAddr and oData to 0, and SHALL drive oAReady=1 and oBReady=1 after release.
REQ-029 Reset mid-operation SHALL discard all pending writes, and no oWE SHALL follow the reset release without a new accept.
REQ-030 The first accept SHALL be allowed on the first clk edge with iRstN high.

Verification
REQ-031 Single A write: A addr 0x18 data 0x1F accepted, clkEn pulses every 4 cycles -> exactly one oWE, oAddr=0x18, oData=0x1F, oGrantB=0, at the cycle after the next clkEn.
REQ-032 B burst: 5 pushes with data 0x10..0x14 and no grants -> oBReady=0 after 4 pushes, oBLevel=4; then releasing clkEn -> 4 oWE, data 0x10..0x13 in order, one per clkEn, and the 5th push accepted once space frees.
REQ-033 Fairness with FAIR_MAX=2: A continuously valid and B holding 3 entries -> grant order A,A,B,A,A,B,...; B is never starved beyond 2 A grants.
REQ-034 Simultaneous push and pop at level 2 -> oBLevel stays 2 and the popped data equals the oldest entry.
REQ-035 Reset mid-operation: A pending and B level 3, iRstN pulsed low asynchronously between edges -> outputs cleared immediately, oBLevel=0, and no oWE during 10 following clkEn cycles without stimulus.
REQ-036 clkEn held low: pending A and B writes -> no oWE until clkEn is asserted, then one grant per clkEn cycle.

Source files
------------

// File: rtl/sid_write_arb.sv
// Two-source write arbiter for the SID register port: a single-entry A holding
// register and a B FIFO, arbitrated on clkEn slots with an A-starvation limit for B.
module sid_write_arb #(
   parameter int FIFO_DEPTH = 4,
   parameter int FAIR_MAX   = 2
) (
   input  logic                        clk,
   input  logic                        iRstN,
   input  logic                        clkEn,
   input  logic                        iAValid,
   output logic                        oAReady,
   input  logic [4:0]                  iAAddr,
   input  logic [7:0]                  iAData,
   input  logic                        iBValid,
   output logic                        oBReady,
   input  logic [4:0]                  iBAddr,
   input  logic [7:0]                  iBData,
   output logic                        oWE,
   output logic [4:0]                  oAddr,
   output logic [7:0]                  oData,
   output logic                        oGrantB,
   output logic [$clog2(FIFO_DEPTH):0] oBLevel
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
   localparam logic [2:0]    FAIR_L  = 3'(FAIR_MAX);

   logic [12:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          a_full_q, a_full_d;
   logic [4:0]    a_addr_q, a_addr_d;
   logic [7:0]    a_data_q, a_data_d;
   logic [2:0]    starve_q, starve_d;
   logic          we_q, we_d;
   logic          grant_b_q, grant_b_d;
   logic [4:0]    addr_q, addr_d;
   logic [7:0]    data_q, data_d;

   logic          a_accept;
   logic          b_push;
   logic          b_pend;
   logic          grant_a;
   logic          grant_b;
   logic [12:0]   b_head;

   always_comb begin
      a_accept = iAValid && !a_full_q;
      b_push   = iBValid && (level_q < DEPTH_L);
      b_pend   = (level_q != '0);
      // Pending state is taken from registers only, so nothing accepted this
      // cycle can be granted before the next cycle.
      grant_a  = clkEn && a_full_q && (!b_pend || (starve_q != FAIR_L));
      grant_b  = clkEn && b_pend && !grant_a;
      b_head   = mem_q[rd_ptr_q];

      a_full_d = a_full_q;
      a_addr_d = a_addr_q;
      a_data_d = a_data_q;
      if (a_accept) begin
         a_full_d = 1'b1;
         a_addr_d = iAAddr;
         a_data_d = iAData;
      end else if (grant_a) begin
         a_full_d = 1'b0;
      end

      wr_ptr_d = b_push  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = grant_b ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (b_push && !grant_b) begin
         level_d = level_q + LW'(1);
      end else if (!b_push && grant_b) begin
         level_d = level_q - LW'(1);
      end

      starve_d = starve_q;
      if (grant_b || !b_pend) begin
         starve_d = 3'd0;
      end else if (grant_a) begin
         starve_d = starve_q + 3'd1;
      end

      we_d      = grant_a || grant_b;
      grant_b_d = grant_b;
      addr_d    = addr_q;
      data_d    = data_q;
      if (grant_a) begin
         addr_d = a_addr_q;
         data_d = a_data_q;
      end else if (grant_b) begin
         addr_d = b_head[12:8];
         data_d = b_head[7:0];
      end
   end

   always_ff @(posedge clk or negedge iRstN) begin
      if (!iRstN) begin
         a_full_q  <= 1'b0;
         a_addr_q  <= '0;
         a_data_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         starve_q  <= '0;
         we_q      <= 1'b0;
         grant_b_q <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         a_full_q  <= a_full_d;
         a_addr_q  <= a_addr_d;
         a_data_q  <= a_data_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         starve_q  <= starve_d;
         we_q      <= we_d;
         grant_b_q <= grant_b_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

   // Storage carries no reset; validity is tracked entirely by the pointers.
   always_ff @(posedge clk) begin
      if (b_push) begin
         mem_q[wr_ptr_q] <= {iBAddr, iBData};
      end
   end

   assign oAReady = !a_full_q;
   assign oBReady = (level_q < DEPTH_L);
   assign oWE     = we_q;
   assign oAddr   = addr_q;
   assign oData   = data_q;
   assign oGrantB = grant_b_q;
   assign oBLevel = level_q;

endmodule

// File: tb/tb_sid_write_arb.sv
// Directed bench for sid_write_arb: latency, FIFO order, fairness, clkEn gating, reset.
module tb_sid_write_arb;

   logic       clk;
   logic       iRstN;
   logic       clkEn;
   logic       iAValid;
   logic       oAReady;
   logic [4:0] iAAddr;
   logic [7:0] iAData;
   logic       iBValid;
   logic       oBReady;
   logic [4:0] iBAddr;
   logic [7:0] iBData;
   logic       oWE;
   logic [4:0] oAddr;
   logic [7:0] oData;
   logic       oGrantB;
   logic [2:0] oBLevel;

   typedef struct {
      logic [4:0] a;
      logic [7:0] d;
      logic       g;
      int         c;
   } wr_t;

   wr_t wq[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  ce_period = 0;
   int  ce_cnt = 0;
   bit  a_stream = 1'b0;

   sid_write_arb #(.FIFO_DEPTH(4), .FAIR_MAX(2)) dut (
      .clk(clk), .iRstN(iRstN), .clkEn(clkEn),
      .iAValid(iAValid), .oAReady(oAReady), .iAAddr(iAAddr), .iAData(iAData),
      .iBValid(iBValid), .oBReady(oBReady), .iBAddr(iBAddr), .iBData(iBData),
      .oWE(oWE), .oAddr(oAddr), .oData(oData), .oGrantB(oGrantB), .oBLevel(oBLevel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (oWE) begin
         wq.push_back('{oAddr, oData, oGrantB, cyc});
         $display("WR cyc=%0d addr=%02h data=%02h src=%s", cyc, oAddr, oData, oGrantB ? "B" : "A");
      end
   end

   task automatic tick();
      bit a_acc;
      a_acc = iAValid && oAReady;
      @(posedge clk);
      #1;
      cyc++;
      if (a_stream && a_acc) iAData = iAData + 8'd1;
      if (ce_period == 0) begin
         clkEn = 1'b0;
      end else begin
         ce_cnt = (ce_cnt + 1) % ce_period;
         clkEn  = (ce_cnt == 0);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_ce(input int p);
      ce_period = p;
      ce_cnt    = 0;
      clkEn     = (p != 0);
   endtask

   task automatic a_write(input logic [4:0] a, input logic [7:0] d);
      bit acc;
      int n;
      iAValid = 1'b1; iAAddr = a; iAData = d;
      acc = 1'b0; n = 0;
      while (!acc && n < 50) begin
         acc = oAReady;
         tick();
         n++;
      end
      iAValid = 1'b0;
      checks++; if (!acc) begin errors++; $display("FAIL a_accept_timeout got=0 exp=1"); end
   endtask

   task automatic b_push(input logic [4:0] a, input logic [7:0] d);
      bit acc;
      int n;
      iBValid = 1'b1; iBAddr = a; iBData = d;
      acc = 1'b0; n = 0;
      while (!acc && n < 50) begin
         acc = oBReady;
         tick();
         n++;
      end
      iBValid = 1'b0;
      checks++; if (!acc) begin errors++; $display("FAIL b_push_timeout got=0 exp=1"); end
   endtask

   task automatic test_reset();
      iRstN = 1'b0; clkEn = 1'b0;
      iAValid = 1'b0; iAAddr = '0; iAData = '0;
      iBValid = 1'b0; iBAddr = '0; iBData = '0;
      #7;
      checks++; if (oWE !== 1'b0) begin errors++; $display("FAIL reset_we got=%0h exp=0", oWE); end
      checks++; if (oAddr !== 5'h00) begin errors++; $display("FAIL reset_addr got=%0h exp=0", oAddr); end
      checks++; if (oData !== 8'h00) begin errors++; $display("FAIL reset_data got=%0h exp=0", oData); end
      checks++; if (oGrantB !== 1'b0) begin errors++; $display("FAIL reset_grantb got=%0h exp=0", oGrantB); end
      checks++; if (oBLevel !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", oBLevel); end
      @(negedge clk);
      iRstN = 1'b1;
      tick();
      checks++; if (oAReady !== 1'b1) begin errors++; $display("FAIL reset_aready got=%0h exp=1", oAReady); end
      checks++; if (oBReady !== 1'b1) begin errors++; $display("FAIL reset_bready got=%0h exp=1", oBReady); end
   endtask

   task automatic test_latency();
      set_ce(1);
      iAValid = 1'b1; iAAddr = 5'h0A; iAData = 8'hA5;
      tick();
      iAValid = 1'b0;
      checks++; if (oWE !== 1'b0) begin errors++; $display("FAIL lat_we_accept got=%0h exp=0", oWE); end
      checks++; if (oAReady !== 1'b0) begin errors++; $display("FAIL lat_aready_full got=%0h exp=0", oAReady); end
      tick();
      checks++; if (oWE !== 1'b1) begin errors++; $display("FAIL lat_we_issue got=%0h exp=1", oWE); end
      checks++; if (oAddr !== 5'h0A) begin errors++; $display("FAIL lat_addr got=%0h exp=0a", oAddr); end
      checks++; if (oData !== 8'hA5) begin errors++; $display("FAIL lat_data got=%0h exp=a5", oData); end
      checks++; if (oGrantB !== 1'b0) begin errors++; $display("FAIL lat_grantb got=%0h exp=0", oGrantB); end
      tick();
      checks++; if (oWE !== 1'b0) begin errors++; $display("FAIL lat_we_oneshot got=%0h exp=0", oWE); end
      checks++; if (oAddr !== 5'h0A) begin errors++; $display("FAIL lat_addr_hold got=%0h exp=0a", oAddr); end
      checks++; if (oGrantB !== 1'b0) begin errors++; $display("FAIL lat_grantb_idle got=%0h exp=0", oGrantB); end
      set_ce(0);
      ticks(2);
   endtask

   task automatic test_single_a();
      wq.delete();
      set_ce(0);
      a_write(5'h18, 8'h1F);
      set_ce(4);
      ticks(12);
      set_ce(0);
      checks++; if (wq.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", wq.size()); end
      checks++; if ((wq.size() > 0 ? wq[0].a : 5'bx) !== 5'h18) begin errors++; $display("FAIL single_addr exp=18"); end
      checks++; if ((wq.size() > 0 ? wq[0].d : 8'bx) !== 8'h1F) begin errors++; $display("FAIL single_data exp=1f"); end
      checks++; if ((wq.size() > 0 ? wq[0].g : 1'bx) !== 1'b0) begin errors++; $display("FAIL single_grantb exp=0"); end
   endtask

   task automatic test_b_burst();
      bit acc;
      int n;
      wq.delete();
      set_ce(0);
      for (int k = 0; k < 4; k++) b_push(5'(k), 8'h10 + 8'(k));
      checks++; if (oBReady !== 1'b0) begin errors++; $display("FAIL burst_bready_full got=%0h exp=0", oBReady); end
      checks++; if (oBLevel !== 3'd4) begin errors++; $display("FAIL burst_level got=%0d exp=4", oBLevel); end
      iBValid = 1'b1; iBAddr = 5'd4; iBData = 8'h14;
      ticks(3);
      checks++; if (oBLevel !== 3'd4) begin errors++; $display("FAIL burst_level_hold got=%0d exp=4", oBLevel); end
      checks++; if (wq.size() != 0) begin errors++; $display("FAIL burst_no_issue got=%0d exp=0", wq.size()); end
      set_ce(4);
      acc = 1'b0; n = 0;
      while (!acc && n < 50) begin
         acc = oBReady;
         tick();
         n++;
      end
      iBValid = 1'b0;
      checks++; if (!acc) begin errors++; $display("FAIL burst_fifth_accept got=0 exp=1"); end
      ticks(30);
      set_ce(0);
      checks++; if (wq.size() != 5) begin errors++; $display("FAIL burst_count got=%0d exp=5", wq.size()); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ((wq.size() > k ? wq[k].d : 8'bx) !== 8'h10 + 8'(k) || (wq.size() > k ? wq[k].g : 1'bx) !== 1'b1) begin
            errors++; $display("FAIL burst_order idx=%0d exp data=%02h src=B", k, 8'h10 + 8'(k));
         end
      end
   endtask

   task automatic test_push_pop();
      wq.delete();
      set_ce(0);
      b_push(5'h01, 8'h21);
      b_push(5'h02, 8'h22);
      checks++; if (oBLevel !== 3'd2) begin errors++; $display("FAIL pp_level_pre got=%0d exp=2", oBLevel); end
      iBValid = 1'b1; iBAddr = 5'h03; iBData = 8'h23;
      clkEn = 1'b1;
      tick();
      iBValid = 1'b0;
      checks++; if (oBLevel !== 3'd2) begin errors++; $display("FAIL pp_level got=%0d exp=2", oBLevel); end
      checks++; if (oWE !== 1'b1) begin errors++; $display("FAIL pp_we got=%0h exp=1", oWE); end
      checks++; if (oData !== 8'h21) begin errors++; $display("FAIL pp_oldest got=%0h exp=21", oData); end
      checks++; if (oGrantB !== 1'b1) begin errors++; $display("FAIL pp_grantb got=%0h exp=1", oGrantB); end
      set_ce(1);
      ticks(6);
      set_ce(0);
      checks++; if (wq.size() != 3) begin errors++; $display("FAIL pp_count got=%0d exp=3", wq.size()); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ((wq.size() > k ? wq[k].d : 8'bx) !== 8'h21 + 8'(k)) begin
            errors++; $display("FAIL pp_order idx=%0d exp=%02h", k, 8'h21 + 8'(k));
         end
      end
   endtask

   task automatic test_fairness();
      bit exp_g [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] exp_d;
      int ai, bi;
      wq.delete();
      set_ce(0);
      for (int k = 0; k < 3; k++) b_push(5'h10, 8'hB0 + 8'(k));
      a_stream = 1'b1;
      iAValid = 1'b1; iAAddr = 5'h01; iAData = 8'hA0;
      ticks(2);
      set_ce(4);
      ticks(44);
      a_stream = 1'b0;
      iAValid = 1'b0;
      ticks(12);
      set_ce(0);
      checks++; if (wq.size() < 9) begin errors++; $display("FAIL fair_count got=%0d exp>=9", wq.size()); end
      ai = 0; bi = 0;
      for (int i = 0; i < 9; i++) begin
         exp_d = exp_g[i] ? 8'hB0 + 8'(bi) : 8'hA0 + 8'(ai);
         if (exp_g[i]) bi++; else ai++;
         checks++;
         if ((wq.size() > i ? wq[i].g : 1'bx) !== exp_g[i]) begin
            errors++; $display("FAIL fair_src idx=%0d exp=%s", i, exp_g[i] ? "B" : "A");
         end
         checks++;
         if ((wq.size() > i ? wq[i].d : 8'bx) !== exp_d) begin
            errors++; $display("FAIL fair_data idx=%0d exp=%02h", i, exp_d);
         end
      end
   endtask

   task automatic test_clken_low();
      wq.delete();
      set_ce(0);
      a_write(5'h05, 8'h55);
      b_push(5'h06, 8'h66);
      ticks(10);
      checks++; if (wq.size() != 0) begin errors++; $display("FAIL cel_no_issue got=%0d exp=0", wq.size()); end
      set_ce(4);
      ticks(12);
      set_ce(0);
      checks++; if (wq.size() != 2) begin errors++; $display("FAIL cel_count got=%0d exp=2", wq.size()); end
      checks++; if ((wq.size() > 0 ? wq[0].d : 8'bx) !== 8'h55 || (wq.size() > 0 ? wq[0].g : 1'bx) !== 1'b0) begin
         errors++; $display("FAIL cel_first exp data=55 src=A");
      end
      checks++; if ((wq.size() > 1 ? wq[1].d : 8'bx) !== 8'h66 || (wq.size() > 1 ? wq[1].g : 1'bx) !== 1'b1) begin
         errors++; $display("FAIL cel_second exp data=66 src=B");
      end
      checks++; if ((wq.size() > 1 ? wq[1].c - wq[0].c : -1) != 4) begin
         errors++; $display("FAIL cel_spacing got=%0d exp=4", wq.size() > 1 ? wq[1].c - wq[0].c : -1);
      end
   endtask

   task automatic test_reset_mid();
      set_ce(0);
      for (int k = 0; k < 3; k++) b_push(5'h07, 8'hC0 + 8'(k));
      a_write(5'h1F, 8'hEE);
      checks++; if (oBLevel !== 3'd3) begin errors++; $display("FAIL rm_level_pre got=%0d exp=3", oBLevel); end
      #2;
      iRstN = 1'b0;
      #1;
      checks++; if (oBLevel !== 3'd0) begin errors++; $display("FAIL rm_level got=%0d exp=0", oBLevel); end
      checks++; if (oAddr !== 5'h00) begin errors++; $display("FAIL rm_addr got=%0h exp=0", oAddr); end
      checks++; if (oData !== 8'h00) begin errors++; $display("FAIL rm_data got=%0h exp=0", oData); end
      checks++; if (oAReady !== 1'b1) begin errors++; $display("FAIL rm_aready got=%0h exp=1", oAReady); end
      #2;
      iRstN = 1'b1;
      wq.delete();
      set_ce(4);
      ticks(44);
      set_ce(0);
      checks++; if (wq.size() != 0) begin errors++; $display("FAIL rm_no_issue got=%0d exp=0", wq.size()); end
      checks++; if (oBReady !== 1'b1) begin errors++; $display("FAIL rm_bready got=%0h exp=1", oBReady); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_single_a();
      test_b_burst();
      test_push_pop();
      test_fairness();
      test_clken_low();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
